// File: rtl/seg_display_monitor_if.sv
// Sampled segment bus from the HEX1/HEX0 display plus the monitor's decode and lock-status outputs.
interface seg_display_monitor_if #(parameter int ERR_W = 8);
  logic             sample;
  logic [6:0]       seg_hi;
  logic [6:0]       seg_lo;
  logic [7:0]       value;
  logic             value_valid;
  logic             bad_pattern;
  logic             seq_err;
  logic             locked;
  logic [1:0]       state;
  logic [ERR_W-1:0] err_count;

  modport master (
    output sample, seg_hi, seg_lo,
    input  value, value_valid, bad_pattern, seq_err, locked, state, err_count
  );

  modport slave (
    input  sample, seg_hi, seg_lo,
    output value, value_valid, bad_pattern, seq_err, locked, state, err_count
  );
endinterface

// File: rtl/seg_display_monitor.sv
// Decodes a two-digit active-low 7-segment bus back to a byte and checks it follows an up-counter.
// Two-stage pipeline (capture, decode/FSM), no back-pressure. Optional SEG_BLANK_SKIP_EN drops all-off digits.
module seg_display_monitor #(
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic                 clk,
  input  logic                 clear,
  seg_display_monitor_if.slave mon
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0011000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = 5'b0;
    endcase
  endfunction

  logic             s1_sample;
  logic [6:0]       s1_hi, s1_lo;
  state_t           state_q, state_n;
  logic [3:0]       run_q, run_n;
  logic [7:0]       last_q, last_n, value_q, value_n;
  logic             vv_q, vv_n, bp_q, bp_n, se_q, se_n;
  logic [ERR_W-1:0] err_q, err_n;

  logic [4:0] dec_hi, dec_lo;
  logic       dec_ok, consistent, blank, fault;
  logic [7:0] dec_val;

  assign dec_hi     = decode(s1_hi);
  assign dec_lo     = decode(s1_lo);
  assign dec_ok     = dec_hi[4] & dec_lo[4];
  assign dec_val    = {dec_hi[3:0], dec_lo[3:0]};
  // A jump to zero is the counter being cleared, so it never breaks the sequence.
  assign consistent = (dec_val == last_q) || (dec_val == last_q + 8'd1) || (dec_val == 8'd0);

`ifdef SEG_BLANK_SKIP_EN
  assign blank = (s1_hi == 7'h7F) || (s1_lo == 7'h7F);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    run_n   = run_q;
    last_n  = last_q;
    value_n = value_q;
    vv_n    = 1'b0;
    bp_n    = 1'b0;
    se_n    = 1'b0;
    err_n   = err_q;
    fault   = 1'b0;
    if (s1_sample && !blank) begin
      if (dec_ok) begin
        vv_n    = 1'b1;
        value_n = dec_val;
        last_n  = dec_val;
        case (state_q)
          HUNT: begin
            run_n   = 4'd1;
            state_n = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
          end
          VERIFY: begin
            if (consistent) begin
              run_n = run_q + 4'd1;
              if (run_q + 4'd1 == LOCK_N) state_n = LOCKED;
            end else begin
              run_n = 4'd1;
            end
          end
          LOCKED:  fault = !consistent;
          default: state_n = HUNT;
        endcase
      end else begin
        bp_n = 1'b1;
        if (state_q == VERIFY) begin
          state_n = HUNT;
          run_n   = 4'd0;
        end else if (state_q == LOCKED) begin
          fault = 1'b1;
        end
      end
    end
    if (fault) begin
      se_n    = 1'b1;
      state_n = HUNT;
      run_n   = 4'd0;
      if (err_q != {ERR_W{1'b1}}) err_n = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      s1_sample <= 1'b0;
      s1_hi     <= 7'd0;
      s1_lo     <= 7'd0;
      state_q   <= HUNT;
      run_q     <= 4'd0;
      last_q    <= 8'd0;
      value_q   <= 8'd0;
      vv_q      <= 1'b0;
      bp_q      <= 1'b0;
      se_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      s1_sample <= mon.sample;
      s1_hi     <= mon.seg_hi;
      s1_lo     <= mon.seg_lo;
      state_q   <= state_n;
      run_q     <= run_n;
      last_q    <= last_n;
      value_q   <= value_n;
      vv_q      <= vv_n;
      bp_q      <= bp_n;
      se_q      <= se_n;
      err_q     <= err_n;
    end
  end

  assign mon.value       = value_q;
  assign mon.value_valid = vv_q;
  assign mon.bad_pattern = bp_q;
  assign mon.seq_err     = se_q;
  assign mon.locked      = (state_q == LOCKED);
  assign mon.state       = state_q;
  assign mon.err_count   = err_q;
endmodule

// File: tb/tb_seg_display_monitor.sv
// Observer bench: a per-sample behavioural model predicts outputs two cycles after each drive; literal checks pin key cases.
module tb_seg_display_monitor;
  localparam int LOCK_CNT = 3;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  seg_display_monitor_if #(.ERR_W(8)) bus ();
  seg_display_monitor_if #(.ERR_W(2)) bus2 ();

  assign bus2.sample = bus.sample;
  assign bus2.seg_hi = bus.seg_hi;
  assign bus2.seg_lo = bus.seg_lo;

  seg_display_monitor #(.ERR_W(8), .LOCK_CNT(LOCK_CNT)) dut     (.clk(clk), .clear(clear), .mon(bus));
  seg_display_monitor #(.ERR_W(2), .LOCK_CNT(LOCK_CNT)) dut_sat (.clk(clk), .clear(clear), .mon(bus2));

  typedef struct {
    logic [7:0] value;
    logic       vv, bp, se;
    int         st;
    int         faults;
  } exp_t;

  exp_t exp_tab [4096];
  bit   have    [4096];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int         m_state = 0, m_run = 0, m_faults = 0;
  logic [7:0] m_last = 8'd0, m_value = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0011000;
      4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;  4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b0001110;
    endcase
  endfunction

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (s == seg_of(4'(i))) return i;
    return -1;
  endfunction

  function automatic int sat(input int f, input int m);
    return (f > m) ? m : f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t reset_snap();
    exp_t e;
    e.value = 8'd0; e.vv = 1'b0; e.bp = 1'b0; e.se = 1'b0; e.st = 0; e.faults = 0;
    return e;
  endfunction

  task automatic model_sample(input logic s, input logic [6:0] h, input logic [6:0] l, output exp_t e);
    int   dh, dl;
    logic blank, cons, fault;
    logic [7:0] v;
    e = reset_snap();
    fault = 1'b0;
`ifdef SEG_BLANK_SKIP_EN
    blank = (h == 7'h7F) || (l == 7'h7F);
`else
    blank = 1'b0;
`endif
    if (s && !blank) begin
      dh = dec(h);
      dl = dec(l);
      if (dh >= 0 && dl >= 0) begin
        v       = 8'(dh * 16 + dl);
        cons    = (v == m_last) || (v == 8'(m_last + 8'd1)) || (v == 8'd0);
        e.vv    = 1'b1;
        m_value = v;
        if (m_state == 0) begin
          m_run   = 1;
          m_state = (LOCK_CNT == 1) ? 2 : 1;
        end else if (m_state == 1) begin
          if (cons) begin
            m_run++;
            if (m_run == LOCK_CNT) m_state = 2;
          end else m_run = 1;
        end else if (!cons) fault = 1'b1;
        m_last = v;
      end else begin
        e.bp = 1'b1;
        if (m_state == 1) begin m_state = 0; m_run = 0; end
        else if (m_state == 2) fault = 1'b1;
      end
      if (fault) begin
        e.se = 1'b1;
        m_faults++;
        m_state = 0;
        m_run   = 0;
      end
    end
    e.value  = m_value;
    e.st     = m_state;
    e.faults = m_faults;
  endtask

  task automatic step(input logic c, input logic s, input logic [6:0] h, input logic [6:0] l);
    exp_t e;
    @(posedge clk);
    #1;
    clear = c; bus.sample = s; bus.seg_hi = h; bus.seg_lo = l;
    if (!c) begin
      m_state = 0; m_run = 0; m_faults = 0; m_last = 8'd0; m_value = 8'd0;
      for (int k = 0; k < 3; k++)
        if (cyc - k >= 0) begin exp_tab[cyc-k] = reset_snap(); have[cyc-k] = 1'b1; end
    end else begin
      model_sample(s, h, l, e);
      exp_tab[cyc] = e;
      have[cyc]    = 1'b1;
    end
  endtask

  task automatic feed(input logic [7:0] v);
    step(1'b1, 1'b1, seg_of(v[7:4]), seg_of(v[3:0]));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 7'h7F, 7'h7F);
  endtask

  task automatic settle();
    idle(); idle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'($urandom), 7'($urandom));
    step(1'b1, 1'b0, 7'd0, 7'd0);
  endtask

  always @(negedge clk) begin
    if (cyc >= 2 && cyc < 4096 && have[cyc-2]) begin
      chk("value",         int'(bus.value),        int'(exp_tab[cyc-2].value));
      chk("value_valid",   int'(bus.value_valid),  int'(exp_tab[cyc-2].vv));
      chk("bad_pattern",   int'(bus.bad_pattern),  int'(exp_tab[cyc-2].bp));
      chk("seq_err",       int'(bus.seq_err),      int'(exp_tab[cyc-2].se));
      chk("state",         int'(bus.state),        exp_tab[cyc-2].st);
      chk("locked",        int'(bus.locked),       (exp_tab[cyc-2].st == 2) ? 1 : 0);
      chk("err_count",     int'(bus.err_count),    sat(exp_tab[cyc-2].faults, 255));
      chk("err_count_sat", int'(bus2.err_count),   sat(exp_tab[cyc-2].faults, 3));
    end
  end

  initial begin
    clear = 1'b0; bus.sample = 1'b1; bus.seg_hi = 7'h2A; bus.seg_lo = 7'h15;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'($urandom), 7'($urandom));
    @(negedge clk);
    chk("lit_reset_state", int'(bus.state), 0);
    chk("lit_reset_value", int'(bus.value), 0);
    chk("lit_reset_err",   int'(bus.err_count), 0);
    chk("lit_reset_lock",  int'(bus.locked), 0);
    step(1'b1, 1'b0, 7'd0, 7'd0);
    settle();
    chk("lit_release_vv", int'(bus.value_valid), 0);

    feed(8'h12);
    idle();
    @(negedge clk);
    chk("lit_lat_early_vv", int'(bus.value_valid), 0);
    idle();
    @(negedge clk);
    chk("lit_lat_vv",    int'(bus.value_valid), 1);
    chk("lit_lat_value", int'(bus.value), 8'h12);

    do_reset();
    feed(8'h05); settle(); chk("lit_lock_s1", int'(bus.state), 1);
    feed(8'h06); settle(); chk("lit_lock_s2", int'(bus.state), 1);
    feed(8'h06); settle(); chk("lit_lock_s3", int'(bus.state), 2);
    chk("lit_locked", int'(bus.locked), 1);

    do_reset();
    feed(8'hFD); feed(8'hFE); feed(8'hFF); feed(8'h00); feed(8'h00); feed(8'h01);
    settle();
    chk("lit_wrap_state", int'(bus.state), 2);

    do_reset();
    feed(8'h0E); feed(8'h0F); feed(8'h10);
    feed(8'h13);
    settle();
    chk("lit_fault_se",    int'(bus.seq_err), 1);
    chk("lit_fault_err",   int'(bus.err_count), 1);
    chk("lit_fault_state", int'(bus.state), 0);
    step(1'b1, 1'b1, 7'h7F, 7'h40);
    settle();
`ifdef SEG_BLANK_SKIP_EN
    chk("lit_bad_bp", int'(bus.bad_pattern), 0);
`else
    chk("lit_bad_bp", int'(bus.bad_pattern), 1);
`endif
    chk("lit_bad_se", int'(bus.seq_err), 0);
    chk("lit_bad_value", int'(bus.value), 8'h13);

    for (int i = 0; i < 5; i++) begin
      feed(8'h20); feed(8'h21); feed(8'h22); feed(8'h50);
    end
    settle();
    chk("lit_sat_err2", int'(bus2.err_count), 3);
    chk("lit_sat_err8", int'(bus.err_count), 6);

    feed(8'h30); feed(8'h31); feed(8'h32);
    step(1'b1, 1'b1, seg_of(4'h3), 7'h7F);
    settle();
`ifdef SEG_BLANK_SKIP_EN
    chk("lit_blank_bp", int'(bus.bad_pattern), 0);
    chk("lit_blank_se", int'(bus.seq_err), 0);
    chk("lit_blank_state", int'(bus.state), 2);
`else
    chk("lit_blank_bp", int'(bus.bad_pattern), 1);
    chk("lit_blank_se", int'(bus.seq_err), 1);
    chk("lit_blank_state", int'(bus.state), 0);
`endif

    feed(8'h44);
    step(1'b0, 1'b0, 7'd0, 7'd0);
    step(1'b1, 1'b0, 7'd0, 7'd0);
    settle();
    chk("lit_midclear_vv", int'(bus.value_valid), 0);
    chk("lit_midclear_value", int'(bus.value), 0);

    idle(); idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_display_monitor.md
Name: seg_display_monitor

Overview:
- Inverse of the counter's 7-segment display path: samples a two-digit active-low segment bus and decodes it back to an 8-bit value.
- Tracks the decoded stream for sequence consistency with an up-counter and counts faults.
- Used as an on-board self-check or bench observer of the HEX1/HEX0 outputs.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- LOCK_CNT, 3, consecutive sequence-consistent samples required to enter LOCKED (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low reset; 0 forces reset state immediately.
- sample  input  1  strobe; segment inputs are captured on a clk edge with sample=1.
- seg_hi  input  7  upper-digit segments, active-low, bit0=a .. bit6=g.
- seg_lo  input  7  lower-digit segments, same encoding.
- value  output  8  last successfully decoded value {hi,lo}.
- value_valid  output  1  one-cycle pulse when value updates.
- bad_pattern  output  1  one-cycle pulse when either digit is undecodable.
- seq_err  output  1  one-cycle pulse on loss of lock.
- locked  output  1  high while state is LOCKED.
- state  output  2  0=HUNT, 1=VERIFY, 2=LOCKED.
- err_count  output  ERR_W  count of seq_err events; saturates at all-ones.

Behaviour:
- Reset values: every output is 0, state=HUNT, internal run counter=0, last value=0.
- Pipeline, one sample accepted per cycle, no back-pressure:
  - Stage 1 registers seg_hi, seg_lo and sample.
  - Stage 2 decodes and updates outputs and the FSM.
  - Sample at edge N -> value_valid/bad_pattern/seq_err at edge N+2.
- Decode table (segments gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Any other pattern on either digit is bad: bad_pattern pulses, value holds, value_valid stays 0.
- A valid sample is consistent when new == last, or new == last+1 mod 256 (255->0 included), or new == 0 (counter clear).
- FSM:
  - HUNT: valid sample -> last=new, run=1; go LOCKED if LOCK_CNT==1, else VERIFY. Bad sample -> stay HUNT.
  - VERIFY, valid and consistent: run+1; on reaching LOCK_CNT go LOCKED.
  - VERIFY, valid and inconsistent: run=1, stay VERIFY.
  - VERIFY, bad sample: go HUNT, run=0.
  - LOCKED, consistent: stay.
  - LOCKED, inconsistent or bad: seq_err pulse, err_count+1 (saturating), go HUNT, run=0.
- last is updated on every valid sample, whatever the state.
- bad_pattern and seq_err may pulse in the same cycle (bad sample while LOCKED).
- Cycles with sample=0 change nothing; all pulses stay 0.
- clear asserted mid-pipeline discards in-flight samples. No pulse is emitted for a sample captured before release.
- err_count is cleared only by clear.

Optional Feature:
- Macro SEG_BLANK_SKIP_EN.
- Defined: all-off pattern 1111111 on either digit is a blanked display. The sample is dropped at stage 2: no value_valid, no bad_pattern, no seq_err, and state, run and last are unchanged.
- Undefined: 1111111 is an ordinary bad pattern.

Test Plan:
- Reset: hold clear=0 with random segments and sample=1 -> all outputs 0, state=0. Release clear -> no pulses in the next 2 cycles.
- Latency/decode: sample {1111001,0100100} at edge N -> value=0x12, value_valid=1 at edge N+2 only.
- Lock: LOCK_CNT=3, feed 0x05,0x06,0x06 -> state 0->1->1->2; locked=1 after the third sample. Feed 0xFF,0x00 while locked -> stays LOCKED.
- Fault: while LOCKED at 0x10, feed 0x13 -> seq_err=1, err_count 0->1, state=HUNT. Feed {0x7F,0x40} -> bad_pattern=1 only.
- Saturation: ERR_W=2, force 5 lock/fault cycles -> err_count sticks at 3.
- Blank: feed 1111111 on seg_lo while LOCKED -> with SEG_BLANK_SKIP_EN no pulses and state stays 2; without it, bad_pattern=1, seq_err=1, state=0.
